// File: rtl/srl_pkg.sv
// Shared types and width helpers for the SRL delay line and its fill controller.
package srl_pkg;

  typedef enum logic {FILL = 1'b0, PRIMED = 1'b1} fill_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Delay values span 0..max_depth inclusive.
  function automatic int dw_of(input int max_depth);
    return clog2(max_depth + 1);
  endfunction

endpackage

// File: rtl/srl_fill_ctrl.sv
// Fill-control FSM: tracks ce-qualified shifts since reset/load and holds the active delay.
module srl_fill_ctrl
  import srl_pkg::*;
#(
  parameter int C_MAX_DEPTH   = 32,
  parameter int C_RESET_DELAY = 1,
  parameter int DW            = dw_of(C_MAX_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          delay_load,
  input  logic [DW-1:0] delay_sel,
  output logic [DW-1:0] delay_cfg,
  output logic          primed
);

  localparam logic [DW-1:0] MAXD    = DW'(C_MAX_DEPTH);
  localparam logic [DW-1:0] RST_CFG = DW'(C_RESET_DELAY);

  fill_state_t   state;
  logic [DW-1:0] fill;
  logic [DW-1:0] fill_nxt;
  logic [DW-1:0] sel_clamped;

  assign sel_clamped = (delay_sel > MAXD) ? MAXD : delay_sel;
  // Counter saturates so it can never wrap back under delay_cfg.
  assign fill_nxt    = (fill == MAXD) ? fill : fill + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      delay_cfg <= RST_CFG;
      fill      <= '0;
      state     <= (C_RESET_DELAY == 0) ? PRIMED : FILL;
    end else if (delay_load) begin
      delay_cfg <= sel_clamped;
      fill      <= '0;
      state     <= (sel_clamped == '0) ? PRIMED : FILL;
    end else if (ce) begin
      fill <= fill_nxt;
      if (state == FILL && fill_nxt >= delay_cfg) state <= PRIMED;
    end
  end

  assign primed = (state == PRIMED);

endmodule

// File: rtl/srl_delay_line.sv
// Programmable-depth data delay line built for SRL inference.
// Optional valid tracking chain enabled by defining SRL_DELAY_VALID_TRACK_EN.
module srl_delay_line
  import srl_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 16,
  parameter int C_MAX_DEPTH   = 32,
  parameter int C_RESET_DELAY = 1,
  localparam int DW           = dw_of(C_MAX_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    delay_load,
  input  logic [DW-1:0]           delay_sel,
  input  logic [C_DATA_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [C_DATA_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    primed,
  output logic [DW-1:0]           delay_cfg
);

  logic [C_MAX_DEPTH-1:0][C_DATA_WIDTH-1:0] stages;
  logic [C_DATA_WIDTH-1:0] tap_d;
  logic                    tap_v;
  logic                    line_valid;

  srl_fill_ctrl #(
    .C_MAX_DEPTH  (C_MAX_DEPTH),
    .C_RESET_DELAY(C_RESET_DELAY),
    .DW           (DW)
  ) u_fill_ctrl (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .delay_load(delay_load),
    .delay_sel (delay_sel),
    .delay_cfg (delay_cfg),
    .primed    (primed)
  );

  // No reset on the data array so it maps onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (ce && !delay_load) begin
      stages[0] <= data_in;
      for (int i = 1; i < C_MAX_DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

`ifdef SRL_DELAY_VALID_TRACK_EN
  logic [C_MAX_DEPTH-1:0] vchain;

  always_ff @(posedge clk) begin
    if (rst || delay_load) begin
      vchain <= '0;
    end else if (ce) begin
      vchain[0] <= valid_in;
      for (int i = 1; i < C_MAX_DEPTH; i++) vchain[i] <= vchain[i-1];
    end
  end
`else
  logic unused_valid_in;
  assign unused_valid_in = valid_in;
`endif

  always_comb begin
    tap_d = '0;
    tap_v = 1'b0;
    for (int i = 0; i < C_MAX_DEPTH; i++) begin
      if (delay_cfg == DW'(i + 1)) begin
        tap_d = stages[i];
`ifdef SRL_DELAY_VALID_TRACK_EN
        tap_v = vchain[i];
`endif
      end
    end
  end

  always_comb begin
`ifdef SRL_DELAY_VALID_TRACK_EN
    line_valid = (delay_cfg == '0) ? valid_in : tap_v;
`else
    line_valid = primed;
`endif
    valid_out = line_valid;
    // Outputs are forced to zero when invalid, which also hides the unreset array.
    if (!line_valid)           data_out = '0;
    else if (delay_cfg == '0)  data_out = data_in;
    else                       data_out = tap_d;
  end

endmodule

// File: tb/tb_srl_delay_line.sv
// Self-checking bench for srl_delay_line against a sample-history reference model.
module tb_srl_delay_line;

  localparam int W    = 16;
  localparam int MAXD = 32;
  localparam int RD   = 1;
  localparam int DW   = 6;
`ifdef SRL_DELAY_VALID_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          ce;
  logic          delay_load;
  logic [DW-1:0] delay_sel;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          primed;
  logic [DW-1:0] delay_cfg;

  srl_delay_line #(
    .C_DATA_WIDTH (W),
    .C_MAX_DEPTH  (MAXD),
    .C_RESET_DELAY(RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .delay_load(delay_load),
    .delay_sel (delay_sel),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .primed    (primed),
    .delay_cfg (delay_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         v;
  } samp_t;

  // Reference: newest sample at index 0, history restarted at every reset/load.
  samp_t hist[$];
  int    cfg_m;
  int    shifts;
  bit    known;
  int    n_chk;
  int    n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic         ev, ep;
    logic [W-1:0] ed;
    if (cfg_m == 0) begin
      ep = 1'b1;
      ev = TRACK ? valid_in : 1'b1;
      ed = data_in;
    end else begin
      ep = (shifts >= cfg_m);
      if (TRACK) ev = (hist.size() >= cfg_m) ? hist[cfg_m-1].v : 1'b0;
      else       ev = ep;
      ed = ev ? hist[cfg_m-1].d : '0;
    end
    if (!ev) ed = '0;
    chk({tag, ".cfg"},    32'(delay_cfg), 32'(cfg_m));
    chk({tag, ".primed"}, 32'(primed),    32'(ep));
    chk({tag, ".valid"},  32'(valid_out), 32'(ev));
    chk({tag, ".data"},   32'(data_out),  32'(ed));
  endtask

  task automatic step(input string tag, input logic r, input logic c, input logic l,
                      input logic [DW-1:0] s, input logic [W-1:0] d, input logic v);
    samp_t sm;
    rst = r; ce = c; delay_load = l; delay_sel = s; data_in = d; valid_in = v;
    #1;
    if (known) check_outputs(tag);
    @(posedge clk);
    if (r) begin
      cfg_m = RD; hist.delete(); shifts = 0; known = 1'b1;
    end else if (l) begin
      cfg_m = (int'(s) > MAXD) ? MAXD : int'(s);
      hist.delete(); shifts = 0;
    end else if (c) begin
      sm.d = d; sm.v = v;
      hist.push_front(sm);
      if (hist.size() > MAXD) void'(hist.pop_back());
      shifts++;
    end
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; known = 1'b0; cfg_m = 0; shifts = 0;
    rst = 1'b1; ce = 1'b0; delay_load = 1'b0; delay_sel = '0; data_in = '0; valid_in = 1'b0;
    #2;

    // Reset overrides ce and load.
    step("rst", 1, 1, 1, 6'd9, 16'h1234, 1);
    step("rst", 1, 1, 0, 6'd0, 16'h5678, 1);
    step("rst_state", 0, 0, 0, 6'd0, 16'h0, 0);

    // Delay 4, ce constant, incrementing data.
    step("load4", 0, 1, 1, 6'd4, 16'h0, 0);
    for (int i = 1; i <= 12; i++) step("ramp", 0, 1, 0, 6'd0, W'(i), 1);

    // ce toggling; output must hold during ce=0.
    for (int i = 0; i < 24; i++)
      step("ce_tog", 0, ~i[0], 0, 6'd0, W'($urandom), 1'($urandom));

    // Over-range load mid-stream clamps to MAXD.
    step("load40", 0, 1, 1, 6'd40, W'($urandom), 1);
    for (int i = 0; i < 40; i++)
      step("deep", 0, 1, 0, 6'd0, W'($urandom), 1'($urandom_range(0, 3) != 0));

    // Zero delay: combinational bypass.
    step("load0", 0, 1, 1, 6'd0, W'($urandom), 1);
    for (int i = 0; i < 6; i++)
      step("bypass", 0, 1'($urandom), 0, 6'd0, W'($urandom), 1'($urandom));

    // Load wins over ce: 0xAAAA must never appear.
    step("load_ce", 0, 1, 1, 6'd4, 16'hAAAA, 1);
    for (int i = 0; i < 8; i++) step("after_lc", 0, 1, 0, 6'd0, W'(16'h100 + i), 1);

    // Reset at fill count 2 of 4.
    step("load4b", 0, 1, 1, 6'd4, 16'h0, 1);
    step("fill1", 0, 1, 0, 6'd0, 16'h0011, 1);
    step("fill2", 0, 1, 0, 6'd0, 16'h0022, 1);
    step("mid_rst", 1, 1, 1, 6'd7, 16'h0033, 1);
    step("post_rst", 0, 1, 0, 6'd0, 16'h0044, 1);

    // Randomized traffic with occasional loads and resets.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), DW'($urandom_range(0, 40)),
           W'($urandom), 1'($urandom_range(0, 4) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_delay_line.md
SRL_DELAY_LINE -- requirements
Module: srl_delay_line

Interface
REQ-001 Parameter C_DATA_WIDTH, default 16: width of the data path in bits, minimum 1.
REQ-002 Parameter C_MAX_DEPTH, default 32: maximum delay in ce-qualified cycles, minimum 1.
REQ-003 Parameter C_RESET_DELAY, default 1: delay applied after reset, range 0..C_MAX_DEPTH.
REQ-004 Clock clk; reset rst, synchronous, active-high.
REQ-005 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port ce, input, 1: clock enable; the shift, the fill count and valid tracking advance only when ce=1.
REQ-008 Port delay_load, input, 1: one-cycle strobe that loads delay_sel into the active delay register.
REQ-009 Port delay_sel, input, DW=clog2(C_MAX_DEPTH+1): requested delay.
REQ-010 Port data_in, input, C_DATA_WIDTH: sample to delay.
REQ-011 Port valid_in, input, 1: data_in qualifier.
REQ-012 Port data_out, output, C_DATA_WIDTH: delayed sample.
REQ-013 Port valid_out, output, 1: data_out qualifier.
REQ-014 Port primed, output, 1: high when the line holds at least delay_cfg shifts since the last reset or load.
REQ-015 Port delay_cfg, output, DW: currently active delay.

Function
REQ-016 The SHALL keep a C_MAX_DEPTH x C_DATA_WIDTH data shift array; each ce=1 cycle shifts data_in into stage 0 and moves every stage n to stage n+1.
REQ-017 For delay_cfg=N>=1, data_out SHALL equal stage N-1, so a sample presented with ce=1 appears after exactly N ce=1 cycles.
REQ-018 For delay_cfg=0, data_out=data_in, valid_out=valid_in and primed=1, all combinationally.
REQ-019 Cycles with ce=0 SHALL freeze the data array, the valid chain, the fill counter and the FSM.
REQ-020 On delay_load, delay_cfg SHALL take delay_sel on the next edge; a delay_sel value above C_MAX_DEPTH SHALL be clamped to C_MAX_DEPTH.
REQ-021 delay_load SHALL take priority over ce: in that cycle there is no shift, the valid chain clears and the fill counter goes to 0.
REQ-022 The fill-control FSM SHALL have the states FILL and PRIMED. It SHALL enter FILL on reset or on delay_load with a nonzero delay, and PRIMED on delay_load with a zero delay.
REQ-023 In FILL, each ce=1 cycle SHALL increment the fill counter. The FSM SHALL move to PRIMED on the edge where the counter reaches delay_cfg. It SHALL stay in PRIMED until reset or delay_load.
REQ-024 primed SHALL be 1 if and only if the FSM is in PRIMED.
REQ-025 The fill counter SHALL saturate at C_MAX_DEPTH and never wrap.
REQ-026 data_out SHALL be forced to zero whenever valid_out=0.

Reset
REQ-027 On rst: valid chain cleared, fill counter=0, delay_cfg=C_RESET_DELAY, FSM=FILL (PRIMED if C_RESET_DELAY=0).
REQ-028 The data array SHALL NOT be reset, which allows SRL inference; the outputs are still defined through REQ-026.
REQ-029 Reset values: valid_out=0, data_out=0, primed=0, delay_cfg=C_RESET_DELAY (for C_RESET_DELAY=0, the bypass rules of REQ-018 apply).
REQ-030 rst SHALL override ce and delay_load when asserted mid-fill or mid-stream.

Configuration
REQ-031 Macro SRL_DELAY_VALID_TRACK_EN defined: a 1-bit valid chain of depth C_MAX_DEPTH shifts valid_in in parallel with the data, and valid_out = chain stage delay_cfg-1.
REQ-032 Macro SRL_DELAY_VALID_TRACK_EN undefined: there is no valid chain, valid_in is ignored, valid_out=primed, and the ports are unchanged.

Structure
REQ-033 The shared package srl_pkg SHALL hold the clog2 constant function, the FSM state typedef (FILL, PRIMED) and the width derivation for DW.
REQ-034 The FSM, fill counter and delay_cfg register SHALL live in the sub-module srl_fill_ctrl; the data and valid arrays stay in srl_delay_line.

Verification
REQ-035 Reset, delay_cfg=4, ce=1 constantly, data 1,2,3,... with valid=1 -> primed rises after the 4th ce cycle; data_out=1 in the cycle after the 4th shift, then increments each cycle.
REQ-036 delay 4, ce toggling 1010... -> each sample emerges after 4 ce=1 cycles (8 clocks); output is held stable during ce=0.
REQ-037 Mid-stream delay_load with delay_sel=40 (C_MAX_DEPTH=32) -> delay_cfg=32, valid_out=0 and primed=0 for 32 ce cycles, then data_out matches input from 32 ce cycles earlier.
REQ-038 delay_load with delay_sel=0 -> next cycle data_out=data_in combinationally, valid_out=valid_in, primed=1.
REQ-039 delay_load and ce both high with data 0xAAAA -> 0xAAAA is never output; fill count=0 afterwards.
REQ-040 rst asserted at fill count 2 of 4 -> next cycle valid_out=0, data_out=0, primed=0, delay_cfg=C_RESET_DELAY; repeat the test with the macro undefined, where valid_out tracks primed.
